pipe_cpu: RTL and testbench
===========================

Name: pipe_cpu

Overview:
- Five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS subset CPU with internal instruction memory, register file and data memory.
- Includes an EX-stage forwarding unit, load-use hazard detection and ID-stage branch resolution with IF/ID flush.
- Top-level processor block; its only external interface is clock and reset. Program load and result inspection go through fixed hierarchical names.

Parameters:
IM_WORDS, 128, instruction memory depth in 32-bit words
DM_WORDS, 128, data memory depth in 32-bit words

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-low

Behaviour:
- Reset (rst_i=0 at a rising edge): PC=0; all pipeline registers cleared (bubble); all 32 registers cleared; data memory cleared. Instruction memory is not affected by reset.
- Hierarchy, fixed for verification: instruction memory instance IM with array Instr_Mem[0:IM_WORDS-1], 32 bits wide, loaded by $readmemb. Register file instance RF with array Reg_File[0:31], 32 bits wide.
- IF:
  - PC is a byte address; fetch Instr_Mem[PC[31:2]]; an out-of-range fetch returns 0.
  - Next PC is PC+4, or the branch target when a beq is taken in ID.
- Instruction 0x00000000 is a NOP. Unsupported opcodes/functs are NOPs: no register or memory write.
- Supported instructions:
  - R-type add(0x20), sub(0x22), and(0x24), or(0x25), slt(0x2A), with write to rd.
  - addi(0x08), slti(0x0A), lw(0x23), sw(0x2B), beq(0x04).
  - Immediates are sign-extended. Arithmetic wraps modulo 2^32 with no overflow trap. slt/slti compare signed.
- Writes to $0 are discarded; $0 always reads 0.
- Register file: write occurs in WB; a read of the register being written in the same cycle returns the new value (write-before-read bypass).
- beq resolves in ID:
  - Target = PC+4 + (sext(imm)<<2).
  - Operands are forwarded from EX/MEM ALU result and the MEM/WB write value.
  - Taken: the fetched instruction in IF/ID is flushed to a bubble, so there is exactly 1 penalty cycle.
- Branch hazards (stall PC and IF/ID, inject bubble into ID/EX):
  - 1 cycle if the instruction in EX writes a beq source register.
  - 1 cycle if a lw in MEM writes a beq source register.
  - A lw in EX feeding a beq stalls 2 cycles in total.
- Load-use: a lw in EX whose rt equals the rs or rt of the instruction in ID gives a 1-cycle stall (PC and IF/ID held, ID/EX bubble).
- EX forwarding, per ALU source, priority order:
  - EX/MEM, when RegWrite and rd≠0 and rd matches.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise the ID/EX register value.
  - The sw store data uses the same forwarding.
- Data memory: word-addressed by ALU result[31:2]. lw reads combinationally in MEM; sw writes at the rising edge. Out-of-range reads return 0; out-of-range writes are ignored.
- Latency: a result is architecturally visible in Reg_File at the rising edge 4 cycles after the instruction leaves IF (WB).
- Reset asserted mid-program: all in-flight instructions are discarded and execution restarts at PC=0.

Test Plan:
- Reset then independent ops (addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$2,$1 spaced with NOPs) -> $1=5, $2=7, $3=12, $4=2, all other registers 0.
- Back-to-back dependencies (addi $1,$0,3; addi $2,$1,4; and $3,$2,$1; or $4,$3,$2; slt $5,$1,$2) with no NOPs -> $2=7, $3=3, $4=7, $5=1; forwarding exercised from both EX/MEM and MEM/WB.
- Memory and load-use (addi $1,$0,-9; sw $1,8($0); lw $2,8($0); add $3,$2,$2) -> $2=-9, $3=-18; exactly one stall cycle inserted before the add.
- Taken beq with flush (addi $1,$0,1; addi $2,$0,1; beq $1,$2,+1; addi $3,$0,99; addi $4,$0,4) -> $3=0, $4=4. Not-taken variant with $2=2 -> $3=99.
- Branch hazard (lw $1,0($0) where mem[0]=0; beq $1,$0,+1; addi $5,$0,1; addi $6,$0,6) -> beq taken after a 2-cycle stall; $5=0, $6=6.
- Writes to $0 and mid-run reset (addi $0,$0,7 -> $0 stays 0); assert rst_i low for 1 cycle mid-program -> PC=0 and registers cleared, then the program reruns to the same final state.

Source files
------------

// File: rtl/pipe_cpu.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with EX forwarding,
// load-use and branch hazard stalls, and beq resolved in ID.

module pipe_cpu_imem #(
   parameter  int IM_WORDS = 128,
   localparam int AW       = $clog2(IM_WORDS)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [29:0]   raddr_i,
   output logic [31:0]   rdata_o
);
   logic [31:0] Instr_Mem [0:IM_WORDS-1];

   always_ff @(posedge clk_i) begin
      if (we_i && (32'(waddr_i) < IM_WORDS)) Instr_Mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = (raddr_i < 30'(IM_WORDS)) ? Instr_Mem[raddr_i[AW-1:0]] : '0;
endmodule

module pipe_cpu_rf (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  ra_i,
   input  logic [4:0]  rb_i,
   output logic [31:0] rda_o,
   output logic [31:0] rdb_o
);
   logic [31:0] Reg_File [0:31];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         Reg_File[waddr_i] <= wdata_i;
      end
   end

   // Same-cycle WB write is visible to the ID read.
   always_comb begin
      rda_o = '0;
      rdb_o = '0;
      if (ra_i != 5'd0) rda_o = (we_i && (waddr_i == ra_i)) ? wdata_i : Reg_File[ra_i];
      if (rb_i != 5'd0) rdb_o = (we_i && (waddr_i == rb_i)) ? wdata_i : Reg_File[rb_i];
   end
endmodule

module pipe_cpu #(
   parameter int IM_WORDS = 128,
   parameter int DM_WORDS = 128
) (
   input logic clk_i,
   input logic rst_i
);
   localparam int IAW = $clog2(IM_WORDS);
   localparam int DAW = $clog2(DM_WORDS);

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
   typedef struct packed {
      logic    rw;
      logic    mr;
      logic    mw;
      logic    src_imm;
      alu_op_e alu;
   } ctrl_t;

   logic [31:0] pc_q, pc_d, pc_plus4, instr_if;
   logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc4_q, ifid_pc4_d;
   ctrl_t       idex_ctrl_q;
   logic [31:0] idex_a_q, idex_b_q, idex_imm_q;
   logic [4:0]  idex_rs_q, idex_rt_q, idex_wreg_q;
   logic        exmem_rw_q, exmem_mr_q, exmem_mw_q;
   logic [31:0] exmem_alu_q, exmem_store_q;
   logic [4:0]  exmem_wreg_q;
   logic        memwb_rw_q;
   logic [4:0]  memwb_wreg_q;
   logic [31:0] memwb_wdata_q;
   logic [31:0] dm_q [0:DM_WORDS-1];

   pipe_cpu_imem #(.IM_WORDS(IM_WORDS)) IM (
      .clk_i(clk_i), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
      .raddr_i(pc_q[31:2]), .rdata_o(instr_if)
   );

   logic [4:0]  id_rs, id_rt, id_rd, id_wreg;
   logic [31:0] id_imm, rf_a, rf_b, br_a, br_b;
   ctrl_t       id_ctrl;
   logic        id_beq, load_use, br_haz, stall, taken;

   assign id_rs  = ifid_instr_q[25:21];
   assign id_rt  = ifid_instr_q[20:16];
   assign id_rd  = ifid_instr_q[15:11];
   assign id_imm = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

   pipe_cpu_rf RF (
      .clk_i(clk_i), .rst_i(rst_i), .we_i(memwb_rw_q), .waddr_i(memwb_wreg_q),
      .wdata_i(memwb_wdata_q), .ra_i(id_rs), .rb_i(id_rt), .rda_o(rf_a), .rdb_o(rf_b)
   );

   always_comb begin
      id_ctrl = '0;
      id_beq  = 1'b0;
      id_wreg = id_rt;
      unique case (ifid_instr_q[31:26])
         6'h00: begin
            id_wreg = id_rd;
            case (ifid_instr_q[5:0])
               6'h20: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b0, alu: ALU_ADD};
               6'h22: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b0, alu: ALU_SUB};
               6'h24: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b0, alu: ALU_AND};
               6'h25: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b0, alu: ALU_OR};
               6'h2A: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b0, alu: ALU_SLT};
               default: id_ctrl = '0;
            endcase
         end
         6'h08: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b1, alu: ALU_ADD};
         6'h0A: id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, src_imm: 1'b1, alu: ALU_SLT};
         6'h23: id_ctrl = '{rw: 1'b1, mr: 1'b1, mw: 1'b0, src_imm: 1'b1, alu: ALU_ADD};
         6'h2B: id_ctrl = '{rw: 1'b0, mr: 1'b0, mw: 1'b1, src_imm: 1'b1, alu: ALU_ADD};
         6'h04: id_beq = 1'b1;
         default: id_ctrl = '0;
      endcase
   end

   // Branch comparator operands: EX/MEM ALU result first, then the WB value.
   always_comb begin
      br_a = rf_a;
      br_b = rf_b;
      if (exmem_rw_q && (exmem_wreg_q != 5'd0) && (exmem_wreg_q == id_rs)) br_a = exmem_alu_q;
      else if (memwb_rw_q && (memwb_wreg_q != 5'd0) && (memwb_wreg_q == id_rs)) br_a = memwb_wdata_q;
      if (exmem_rw_q && (exmem_wreg_q != 5'd0) && (exmem_wreg_q == id_rt)) br_b = exmem_alu_q;
      else if (memwb_rw_q && (memwb_wreg_q != 5'd0) && (memwb_wreg_q == id_rt)) br_b = memwb_wdata_q;
   end

   assign load_use = idex_ctrl_q.mr && ((idex_wreg_q == id_rs) || (idex_wreg_q == id_rt));
   assign br_haz   = id_beq && (
                       (idex_ctrl_q.rw && (idex_wreg_q != 5'd0) &&
                        ((idex_wreg_q == id_rs) || (idex_wreg_q == id_rt))) ||
                       (exmem_mr_q && (exmem_wreg_q != 5'd0) &&
                        ((exmem_wreg_q == id_rs) || (exmem_wreg_q == id_rt))));
   assign stall    = load_use || br_haz;
   assign taken    = id_beq && !stall && (br_a == br_b);
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d         = pc_plus4;
      ifid_instr_d = instr_if;
      ifid_pc4_d   = pc_plus4;
      if (stall) begin
         pc_d         = pc_q;
         ifid_instr_d = ifid_instr_q;
         ifid_pc4_d   = ifid_pc4_q;
      end else if (taken) begin
         pc_d         = ifid_pc4_q + {id_imm[29:0], 2'b00};
         ifid_instr_d = '0;
         ifid_pc4_d   = '0;
      end
   end

   logic [31:0] ex_a, ex_b, alu_b, alu_y;

   always_comb begin
      ex_a = idex_a_q;
      ex_b = idex_b_q;
      if (exmem_rw_q && (exmem_wreg_q != 5'd0) && (exmem_wreg_q == idex_rs_q)) ex_a = exmem_alu_q;
      else if (memwb_rw_q && (memwb_wreg_q != 5'd0) && (memwb_wreg_q == idex_rs_q)) ex_a = memwb_wdata_q;
      if (exmem_rw_q && (exmem_wreg_q != 5'd0) && (exmem_wreg_q == idex_rt_q)) ex_b = exmem_alu_q;
      else if (memwb_rw_q && (memwb_wreg_q != 5'd0) && (memwb_wreg_q == idex_rt_q)) ex_b = memwb_wdata_q;
   end

   assign alu_b = idex_ctrl_q.src_imm ? idex_imm_q : ex_b;

   always_comb begin
      case (idex_ctrl_q.alu)
         ALU_SUB: alu_y = ex_a - alu_b;
         ALU_AND: alu_y = ex_a & alu_b;
         ALU_OR:  alu_y = ex_a | alu_b;
         ALU_SLT: alu_y = {31'd0, $signed(ex_a) < $signed(alu_b)};
         default: alu_y = ex_a + alu_b;
      endcase
   end

   logic        dm_in_range;
   logic [31:0] dm_rdata, mem_wdata;

   assign dm_in_range = exmem_alu_q[31:2] < 30'(DM_WORDS);
   assign dm_rdata    = dm_in_range ? dm_q[exmem_alu_q[DAW+1:2]] : '0;
   assign mem_wdata   = exmem_mr_q ? dm_rdata : exmem_alu_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_q          <= '0;
         ifid_instr_q  <= '0;
         ifid_pc4_q    <= '0;
         idex_ctrl_q   <= '0;
         idex_a_q      <= '0;
         idex_b_q      <= '0;
         idex_imm_q    <= '0;
         idex_rs_q     <= '0;
         idex_rt_q     <= '0;
         idex_wreg_q   <= '0;
         exmem_rw_q    <= 1'b0;
         exmem_mr_q    <= 1'b0;
         exmem_mw_q    <= 1'b0;
         exmem_alu_q   <= '0;
         exmem_store_q <= '0;
         exmem_wreg_q  <= '0;
         memwb_rw_q    <= 1'b0;
         memwb_wreg_q  <= '0;
         memwb_wdata_q <= '0;
         for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= '0;
      end else begin
         pc_q          <= pc_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc4_q    <= ifid_pc4_d;
         idex_ctrl_q   <= stall ? '0 : id_ctrl;
         idex_a_q      <= stall ? '0 : rf_a;
         idex_b_q      <= stall ? '0 : rf_b;
         idex_imm_q    <= stall ? '0 : id_imm;
         idex_rs_q     <= stall ? '0 : id_rs;
         idex_rt_q     <= stall ? '0 : id_rt;
         idex_wreg_q   <= stall ? '0 : id_wreg;
         exmem_rw_q    <= idex_ctrl_q.rw;
         exmem_mr_q    <= idex_ctrl_q.mr;
         exmem_mw_q    <= idex_ctrl_q.mw;
         exmem_alu_q   <= alu_y;
         exmem_store_q <= ex_b;
         exmem_wreg_q  <= idex_wreg_q;
         memwb_rw_q    <= exmem_rw_q;
         memwb_wreg_q  <= exmem_wreg_q;
         memwb_wdata_q <= mem_wdata;
         if (exmem_mw_q && dm_in_range) dm_q[exmem_alu_q[DAW+1:2]] <= exmem_store_q;
      end
   end
endmodule

// File: tb/tb_pipe_cpu.sv
// Program-level bench for pipe_cpu: expected register values are queued when a
// program is loaded and compared against the register file after it runs.

module tb_pipe_cpu;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   always #5 clk_i = ~clk_i;

   pipe_cpu #(.IM_WORDS(128), .DM_WORDS(128)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i)
   );

   typedef struct {
      string       name;
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
   localparam logic [31:0] NOP = 32'h0;

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   task automatic expect_reg(input string name, input int idx, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.idx  = idx;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic start_prog();
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < 128; i++)
         dut.IM.Instr_Mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      prog = {};
      start_prog();
      n_checks++;
      if (dut.pc_q !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_pc: got %h expected %h", dut.pc_q, 32'h0);
      end
      n_checks++;
      if (dut.ifid_instr_q !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ifid: got %h expected %h", dut.ifid_instr_q, 32'h0);
      end
      for (int r = 0; r < 32; r++) expect_reg($sformatf("reset r%0d", r), r, 32'h0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_independent();
      exp_t e;
      prog = {enc_i(OP_ADDI, 1, 0, 5), NOP, NOP, NOP,
              enc_i(OP_ADDI, 2, 0, 7), NOP, NOP, NOP,
              enc_r(F_ADD, 3, 1, 2), NOP, NOP, NOP,
              enc_r(F_SUB, 4, 2, 1)};
      for (int r = 0; r < 32; r++)
         expect_reg($sformatf("indep r%0d", r), r,
                    (r == 1) ? 32'd5 : (r == 2) ? 32'd7 : (r == 3) ? 32'd12 : (r == 4) ? 32'd2 : 32'd0);
      start_prog();
      run(30);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      prog = {enc_i(OP_ADDI, 1, 0, 3), enc_i(OP_ADDI, 2, 1, 4), enc_r(F_AND, 3, 2, 1),
              enc_r(F_OR, 4, 3, 2), enc_r(F_SLT, 5, 1, 2)};
      expect_reg("b2b r1", 1, 32'd3);
      expect_reg("b2b r2", 2, 32'd7);
      expect_reg("b2b r3", 3, 32'd3);
      expect_reg("b2b r4", 4, 32'd7);
      expect_reg("b2b r5", 5, 32'd1);
      start_prog();
      run(20);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      prog = {enc_i(OP_ADDI, 1, 0, -9), enc_i(OP_SW, 1, 0, 8), enc_i(OP_LW, 2, 0, 8),
              enc_r(F_ADD, 3, 2, 2)};
      expect_reg("lu r1", 1, 32'hFFFF_FFF7);
      expect_reg("lu r2", 2, 32'hFFFF_FFF7);
      expect_reg("lu r3", 3, 32'hFFFF_FFEE);
      start_prog();
      // add retires at edge 9 with one stall; edge 8 without.
      run(8);
      n_checks++;
      if (dut.RF.Reg_File[3] !== 32'h0) begin
         n_fail++;
         $display("FAIL lu_stall_edge8: got %h expected %h", dut.RF.Reg_File[3], 32'h0);
      end
      run(1);
      n_checks++;
      if (dut.RF.Reg_File[3] !== 32'hFFFF_FFEE) begin
         n_fail++;
         $display("FAIL lu_stall_edge9: got %h expected %h", dut.RF.Reg_File[3], 32'hFFFF_FFEE);
      end
      run(10);
      n_checks++;
      if (dut.dm_q[2] !== 32'hFFFF_FFF7) begin
         n_fail++;
         $display("FAIL lu_mem2: got %h expected %h", dut.dm_q[2], 32'hFFFF_FFF7);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_branch(input int r2_val);
      exp_t  e;
      string tag;
      tag  = (r2_val == 1) ? "beq_taken" : "beq_not_taken";
      prog = {enc_i(OP_ADDI, 1, 0, 1), enc_i(OP_ADDI, 2, 0, r2_val), enc_i(OP_BEQ, 2, 1, 1),
              enc_i(OP_ADDI, 3, 0, 99), enc_i(OP_ADDI, 4, 0, 4)};
      expect_reg({tag, " r2"}, 2, 32'(r2_val));
      expect_reg({tag, " r3"}, 3, (r2_val == 1) ? 32'd0 : 32'd99);
      expect_reg({tag, " r4"}, 4, 32'd4);
      start_prog();
      if (r2_val == 1) begin
         // 1 hazard stall + 1 flush cycle: $4 lands at edge 10.
         run(9);
         n_checks++;
         if (dut.RF.Reg_File[4] !== 32'h0) begin
            n_fail++;
            $display("FAIL beq_taken_edge9: got %h expected %h", dut.RF.Reg_File[4], 32'h0);
         end
         run(1);
         n_checks++;
         if (dut.RF.Reg_File[4] !== 32'd4) begin
            n_fail++;
            $display("FAIL beq_taken_edge10: got %h expected %h", dut.RF.Reg_File[4], 32'd4);
         end
      end
      run(20);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_branch_hazard();
      exp_t e;
      prog = {enc_i(OP_LW, 1, 0, 0), enc_i(OP_BEQ, 0, 1, 1), enc_i(OP_ADDI, 5, 0, 1),
              enc_i(OP_ADDI, 6, 0, 6)};
      expect_reg("bh r1", 1, 32'd0);
      expect_reg("bh r5", 5, 32'd0);
      expect_reg("bh r6", 6, 32'd6);
      start_prog();
      // Two stall cycles + flush: $6 lands at edge 10.
      run(9);
      n_checks++;
      if (dut.RF.Reg_File[6] !== 32'h0) begin
         n_fail++;
         $display("FAIL bh_edge9: got %h expected %h", dut.RF.Reg_File[6], 32'h0);
      end
      run(1);
      n_checks++;
      if (dut.RF.Reg_File[6] !== 32'd6) begin
         n_fail++;
         $display("FAIL bh_edge10: got %h expected %h", dut.RF.Reg_File[6], 32'd6);
      end
      run(10);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   task automatic test_zero_and_midreset();
      exp_t e;
      prog = {enc_i(OP_ADDI, 0, 0, 7), enc_i(OP_ADDI, 1, 0, -3), enc_i(OP_SLTI, 2, 1, 1),
              enc_r(F_SUB, 3, 0, 1), enc_i(OP_SW, 3, 0, 4), enc_i(OP_LW, 4, 0, 4),
              enc_r(F_OR, 5, 4, 2)};
      start_prog();
      run(9);
      n_checks++;
      if (dut.RF.Reg_File[1] !== 32'hFFFF_FFFD) begin
         n_fail++;
         $display("FAIL mid_pre_r1: got %h expected %h", dut.RF.Reg_File[1], 32'hFFFF_FFFD);
      end
      n_checks++;
      if (dut.dm_q[1] !== 32'd3) begin
         n_fail++;
         $display("FAIL mid_pre_mem1: got %h expected %h", dut.dm_q[1], 32'd3);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (dut.pc_q !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_rst_pc: got %h expected %h", dut.pc_q, 32'h0);
      end
      n_checks++;
      if (dut.dm_q[1] !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_rst_mem1: got %h expected %h", dut.dm_q[1], 32'h0);
      end
      for (int r = 0; r < 32; r++) begin
         n_checks++;
         if (dut.RF.Reg_File[r] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst_r%0d: got %h expected %h", r, dut.RF.Reg_File[r], 32'h0);
         end
      end
      expect_reg("rerun r0", 0, 32'd0);
      expect_reg("rerun r1", 1, 32'hFFFF_FFFD);
      expect_reg("rerun r2", 2, 32'd1);
      expect_reg("rerun r3", 3, 32'd3);
      expect_reg("rerun r4", 4, 32'd3);
      expect_reg("rerun r5", 5, 32'd3);
      @(negedge clk_i);
      rst_i = 1'b1;
      run(30);
      n_checks++;
      if (dut.dm_q[1] !== 32'd3) begin
         n_fail++;
         $display("FAIL rerun_mem1: got %h expected %h", dut.dm_q[1], 32'd3);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         if (dut.RF.Reg_File[e.idx] !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, dut.RF.Reg_File[e.idx], e.val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_independent();
      test_back_to_back();
      test_load_use();
      test_branch(1);
      test_branch(2);
      test_branch_hazard();
      test_zero_and_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
